// File: rtl/generador_mdio_if.sv
`default_nettype none
// ============================================================================
// Module      : generador_mdio_if
// Description : Host/PHY-facing bundle of the MDIO station-management controller.
//               The slave modport is the controller; master is the host side.
// Revision    : 1.0  initial release
// ============================================================================
interface generador_mdio_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        MDIO_DONE;
    logic        BUSY;

    modport master (
        output MDIO_START,
        output T_DATA,
        output MDIO_IN,
        input  MDC,
        input  MDIO_OUT,
        input  MDIO_OE,
        input  RD_DATA,
        input  DATA_RDY,
        input  MDIO_DONE,
        input  BUSY
    );

    modport slave (
        input  MDIO_START,
        input  T_DATA,
        input  MDIO_IN,
        output MDC,
        output MDIO_OUT,
        output MDIO_OE,
        output RD_DATA,
        output DATA_RDY,
        output MDIO_DONE,
        output BUSY
    );
endinterface
`default_nettype wire

// File: rtl/generador_mdio.sv
`default_nettype none
// ============================================================================
// Module      : generador_mdio
// Description : MDIO management frame generator; serialises a 32-bit frame on
//               MDC = CLK/2 and captures 16 read-data bits from the PHY.
// Revision    : 1.0  initial release
// ============================================================================
module generador_mdio (
    input  wire logic       CLK,
    input  wire logic       RESET,
    generador_mdio_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] c_LAST_DRIVEN_READ = 7'd27;  // low phase of bit 13
    localparam logic [6:0] c_FIRST_CAPTURE    = 7'd35;  // edge ending bit 16
    localparam logic [6:0] c_LAST_CYCLE       = 7'd64;  // high phase of bit 31

    state_t      r_state;
    logic [31:0] r_frame;
    logic        r_is_read;
    logic [5:0]  r_step;
    logic [15:0] r_cap;

    logic        r_mdc;
    logic        r_mdio_out;
    logic        r_mdio_oe;
    logic [15:0] r_rd_data;
    logic        r_data_rdy;
    logic        r_mdio_done;
    logic        r_busy;

    // w_n is the cycle number (1..64) whose outputs are being registered now;
    // odd cycles are MDC-low phases, even cycles are MDC-high phases.
    logic [6:0]  w_n;
    logic        w_low;
    logic        w_drive;

    assign w_n     = {1'b0, r_step} + 7'd1;
    assign w_low   = w_n[0];
    assign w_drive = !r_is_read || (w_n <= c_LAST_DRIVEN_READ);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_frame     <= 32'd0;
            r_is_read   <= 1'b0;
            r_step      <= 6'd0;
            r_cap       <= 16'd0;
            r_mdc       <= 1'b0;
            r_mdio_out  <= 1'b0;
            r_mdio_oe   <= 1'b0;
            r_rd_data   <= 16'd0;
            r_data_rdy  <= 1'b0;
            r_mdio_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mdc       <= 1'b0;
                    r_mdio_out  <= 1'b0;
                    r_mdio_oe   <= 1'b0;
                    r_data_rdy  <= 1'b0;
                    r_mdio_done <= 1'b0;
                    r_busy      <= 1'b0;
                    if (bus.MDIO_START) begin
                        r_frame   <= bus.T_DATA;
                        r_is_read <= (bus.T_DATA[29:28] == 2'b10);
                        r_step    <= 6'd0;
                        r_cap     <= 16'd0;
                        r_state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_step <= r_step + 6'd1;
                    r_mdc  <= ~w_low;
                    r_busy <= 1'b1;
                    if (w_low) begin
                        // Entering a low phase: present the next frame bit and
                        // sample the PHY bit that was held through the last high phase.
                        r_mdio_oe  <= w_drive;
                        r_mdio_out <= w_drive & r_frame[31];
                        r_frame    <= {r_frame[30:0], 1'b0};
                        if (r_is_read && (w_n >= c_FIRST_CAPTURE)) begin
                            r_cap <= {r_cap[14:0], bus.MDIO_IN};
                        end
                    end
                    if (w_n == c_LAST_CYCLE) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    // The edge leaving the final high phase samples bit 31 and
                    // publishes the completion outputs in the same cycle.
                    r_mdc       <= 1'b0;
                    r_mdio_out  <= 1'b0;
                    r_mdio_oe   <= 1'b0;
                    r_mdio_done <= 1'b1;
                    r_busy      <= 1'b1;
                    if (r_is_read) begin
                        r_rd_data  <= {r_cap[14:0], bus.MDIO_IN};
                        r_data_rdy <= 1'b1;
                    end
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.MDC       = r_mdc;
    assign bus.MDIO_OUT  = r_mdio_out;
    assign bus.MDIO_OE   = r_mdio_oe;
    assign bus.RD_DATA   = r_rd_data;
    assign bus.DATA_RDY  = r_data_rdy;
    assign bus.MDIO_DONE = r_mdio_done;
    assign bus.BUSY      = r_busy;

endmodule
`default_nettype wire
